alu: RTL and testbench
======================

Name: alu

Overview:
- 32-bit ALU with a small neuron datapath. It performs add, subtract, AND and OR on A/B.
- It also evaluates a 3-input neuron, ReLU(W1·A + W2·B + W3·C), using three internal weight registers.
- The weight registers are loaded from A/B/C by a dedicated opcode.
- It sits in the processor execute stage; the result y is combinational, and the only clocked state is the weight registers.

Parameters:
- WIDTH, 32, data width of A, B, C, y and of each weight register.

Ports:
- clk  input  1  system clock; weight registers update on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- A  input  WIDTH  operand A; also the W1 load source.
- B  input  WIDTH  operand B; also the W2 load source.
- C  input  WIDTH  operand C; also the W3 load source.
- ALUSRC  input  3  operation select.
- y  output  WIDTH  result.

Behaviour:
- Interface is fixed: one clock (clk); reset rst_n is asynchronous and active-low.
- State:
  - W1, W2, W3 are WIDTH-bit signed registers.
  - rst_n=0 clears all three to 0 immediately, independent of clk.
  - Reset dominates a simultaneous load.
- Weight load:
  - On a rising clk edge with rst_n=1 and ALUSRC=3'b101: W1<=A, W2<=B, W3<=C.
  - Otherwise the weights hold.
  - The load takes effect for ANN results after that edge; there is no other latency.
- y is purely combinational from the current ALUSRC, A, B, C and the registered weights. It is not registered and has zero-cycle latency.
- Opcodes:
  - 000: y = A + B, modulo 2^WIDTH; carry discarded.
  - 001: y = A − B, modulo 2^WIDTH; borrow discarded.
  - 010: y = A & B.
  - 011: y = A | B.
  - 100 (ANN): operands and weights are signed two's complement.
    - Products are full-precision (2·WIDTH bits) and are summed in at least 2·WIDTH+2 bits; there is no intermediate truncation.
    - sum < 0 → y = 0 (ReLU).
    - sum > 2^(WIDTH−1)−1 → y = 32'h7FFFFFFF (saturate).
    - otherwise y = sum[WIDTH−1:0].
  - 101: y = 0 while loading.
  - 110, 111: reserved; y = 0; weights unaffected.
- During reset (rst_n=0): y still follows the table, with weights reading 0, so ANN gives y = 0.
- No X propagation: every opcode drives a defined y.

Test Plan:
- Reset, then A=B=C=3, ALUSRC=101 across one rising edge → W1=W2=W3=3, y=0. Then:
  - ALUSRC=000 → y=6
  - 001 → y=0
  - 100 → y=0x1B
  - 011 → y=3
  - 010 → y=3
- With ALUSRC=010, set A=0xFFFFFFFF, B=0, C=1 → y=0. Then:
  - ALUSRC=101 for one edge → W1=−1, W2=0, W3=1.
  - ALUSRC=100 → y=2.
- Wrap: A=0xFFFFFFFF, B=1:
  - ALUSRC=000 → y=0.
  - ALUSRC=001 with A=0, B=1 → y=0xFFFFFFFF.
- ReLU: weights 3,3,3; ALUSRC=100, A=0xFFFFFFFB (−5), B=C=0 → y=0.
- Saturation: load A=B=C=0x40000000 via 101, then ALUSRC=100 with the same operands → y=0x7FFFFFFF.
- Async reset: after loading weights 3,3,3, pulse rst_n low between clock edges with ALUSRC=100, A=B=C=3 → y drops to 0 immediately and stays 0 after rst_n returns high. Also 110/111 → y=0 with weights unchanged.

Source files
------------

// File: rtl/alu.sv
// 32-bit ALU (add/sub/and/or) plus ReLU neuron over three registered weights.
// y is combinational with zero latency; the weights load on opcode 101; no backpressure.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [2:0]       ALUSRC,
  output logic [WIDTH-1:0] y
);

  localparam int PW = 2 * WIDTH;
  localparam int SW = PW + 2;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_ANN  = 3'b100;
  localparam logic [2:0] OP_LOAD = 3'b101;

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};

  logic signed [WIDTH-1:0] w1, w2, w3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w1 <= '0;
      w2 <= '0;
      w3 <= '0;
    end else if (ALUSRC == OP_LOAD) begin
      w1 <= A;
      w2 <= B;
      w3 <= C;
    end
  end

  // Operands are sign-extended to the product width so the low 2*WIDTH bits of
  // each product are the exact signed result.
  logic signed [PW-1:0] a_ext, b_ext, c_ext;
  logic signed [PW-1:0] w1_ext, w2_ext, w3_ext;
  logic signed [PW-1:0] p1, p2, p3;
  logic signed [SW-1:0] sum;
  logic                 sum_neg;
  logic                 sum_ovf;
  logic [WIDTH-1:0]     ann;

  always_comb begin
    a_ext  = {{WIDTH{A[WIDTH-1]}}, A};
    b_ext  = {{WIDTH{B[WIDTH-1]}}, B};
    c_ext  = {{WIDTH{C[WIDTH-1]}}, C};
    w1_ext = {{WIDTH{w1[WIDTH-1]}}, w1};
    w2_ext = {{WIDTH{w2[WIDTH-1]}}, w2};
    w3_ext = {{WIDTH{w3[WIDTH-1]}}, w3};
    p1     = w1_ext * a_ext;
    p2     = w2_ext * b_ext;
    p3     = w3_ext * c_ext;
    sum    = {{2{p1[PW-1]}}, p1} + {{2{p2[PW-1]}}, p2} + {{2{p3[PW-1]}}, p3};
  end

  // A non-negative sum exceeds the positive WIDTH-bit range iff any bit at or
  // above the WIDTH-1 position is set.
  always_comb begin
    sum_neg = sum[SW-1];
    sum_ovf = |sum[SW-2:WIDTH-1];
    if (sum_neg)
      ann = '0;
    else if (sum_ovf)
      ann = SAT_MAX;
    else
      ann = sum[WIDTH-1:0];
  end

  always_comb begin
    y = '0;
    unique case (ALUSRC)
      OP_ADD:  y = A + B;
      OP_SUB:  y = A - B;
      OP_AND:  y = A & B;
      OP_OR:   y = A | B;
      OP_ANN:  y = ann;
      default: y = '0;
    endcase
  end

endmodule

// File: tb/tb_alu.sv
// Directed vector table for the ALU/neuron plus hand sequences for reset corners.
`timescale 1ns/1ps
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] A, B, C;
  logic [2:0]  ALUSRC;
  logic [31:0] y;

  int checks   = 0;
  int failures = 0;

  alu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .ALUSRC(ALUSRC), .y(y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] c, input logic [31:0] exp);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.c = c; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] exp);
    checks++;
    if (y !== exp) begin
      failures++;
      $display("FAIL %s: y=%h expected=%h", name, y, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] c);
    ALUSRC = op; A = a; B = b; C = c;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(3'b100, 32'd5, 32'd5, 32'd5);
    #1 check("reset_ann", 32'h0);
    ALUSRC = 3'b000;
    #1 check("reset_add", 32'd10);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Each entry is applied on a falling edge; a 101 entry loads on the next rising edge.
    add("ann_zero_w",   3'b100, 32'd5,        32'd5,        32'd5,  32'h0);
    add("load_3s",      3'b101, 32'd3,        32'd3,        32'd3,  32'h0);
    add("add_3_3",      3'b000, 32'd3,        32'd3,        32'd3,  32'd6);
    add("sub_3_3",      3'b001, 32'd3,        32'd3,        32'd3,  32'd0);
    add("ann_3s",       3'b100, 32'd3,        32'd3,        32'd3,  32'h1B);
    add("or_3_3",       3'b011, 32'd3,        32'd3,        32'd3,  32'd3);
    add("and_3_3",      3'b010, 32'd3,        32'd3,        32'd3,  32'd3);
    add("and_ff_0",     3'b010, 32'hFFFFFFFF, 32'h0,        32'd1,  32'h0);
    add("load_m1_0_1",  3'b101, 32'hFFFFFFFF, 32'h0,        32'd1,  32'h0);
    add("ann_m1_0_1",   3'b100, 32'hFFFFFFFF, 32'h0,        32'd1,  32'd2);
    add("add_wrap",     3'b000, 32'hFFFFFFFF, 32'd1,        32'd0,  32'h0);
    add("sub_wrap",     3'b001, 32'h0,        32'd1,        32'd0,  32'hFFFFFFFF);
    add("sub_5_7",      3'b001, 32'd5,        32'd7,        32'd0,  32'hFFFFFFFE);
    add("and_pat",      3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,  32'hF000F000);
    add("or_pat",       3'b011, 32'hF0F0F0F0, 32'h0F0F0000, 32'd0,  32'hFFFFF0F0);
    add("rsv_110",      3'b110, 32'd3,        32'd3,        32'd3,  32'h0);
    add("rsv_111",      3'b111, 32'd3,        32'd3,        32'd3,  32'h0);
    add("ann_w_kept",   3'b100, 32'd1,        32'd9,        32'd7,  32'd6);
    add("reload_3s",    3'b101, 32'd3,        32'd3,        32'd3,  32'h0);
    add("relu_neg",     3'b100, 32'hFFFFFFFB, 32'h0,        32'h0,  32'h0);
    add("ann_1_2_3",    3'b100, 32'd1,        32'd2,        32'd3,  32'h12);
    add("ann_mix_neg",  3'b100, 32'hFFFFFFFF, 32'd0,        32'd1,  32'h0);
    add("load_big",     3'b101, 32'h40000000, 32'h40000000, 32'h40000000, 32'h0);
    add("ann_sat",      3'b100, 32'h40000000, 32'h40000000, 32'h40000000, 32'h7FFFFFFF);
    add("ann_2p30",     3'b100, 32'd1,        32'd0,        32'd0,  32'h40000000);
    add("ann_2p31",     3'b100, 32'd1,        32'd1,        32'd0,  32'h7FFFFFFF);
    add("ann_cancel",   3'b100, 32'd1,        32'd1,        32'hFFFFFFFF, 32'h40000000);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c);
      #1 check(vecs[i].name, vecs[i].exp);
    end

    // Asynchronous reset pulse between edges with weights 3,3,3.
    @(negedge clk);
    drive(3'b101, 32'd3, 32'd3, 32'd3);
    @(negedge clk);
    drive(3'b100, 32'd3, 32'd3, 32'd3);
    #1 check("pre_rst_ann", 32'h1B);
    rst_n = 1'b0;
    #1 check("rst_async_ann", 32'h0);
    ALUSRC = 3'b000;
    #1 check("rst_add_live", 32'd6);
    ALUSRC = 3'b100;
    rst_n = 1'b1;
    #1 check("post_rst_ann", 32'h0);
    @(posedge clk);
    #1 check("post_rst_edge", 32'h0);

    // Reset held across a load edge must win over the load.
    @(negedge clk);
    rst_n = 1'b0;
    drive(3'b101, 32'd3, 32'd3, 32'd3);
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'b100, 32'd3, 32'd3, 32'd3);
    #1 check("rst_beats_load", 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
